// File: rtl/spi_ram_cmd.sv
// rtl/spi_ram_cmd.sv - command-decoding single-port RAM behind the SPI slave
//
// Purpose:
//   Decodes 10-bit words {cmd[1:0], payload[7:0]} from the SPI slave into
//   write-address / write-data / read-address / read-data operations on an
//   8-bit wide single-port memory, returning read data to the slave for MISO.
//   A four-state address-armed FSM rejects data commands issued before the
//   matching address has been loaded.
//
// Ports:
//   clk       in   1             single clock, all logic on posedge
//   rst       in   1             synchronous active-high reset
//   rx_data   in   ADDR_SIZE+2   [ADDR_SIZE+1:ADDR_SIZE] = cmd, [ADDR_SIZE-1:0] = payload
//   rx_valid  in   1             one-cycle strobe qualifying rx_data
//   tx_data   out  8             read data (holds last value between reads)
//   tx_valid  out  1             one-cycle strobe, tx_data valid
//   seq_err   out  1             one-cycle strobe, illegal command order (dropped)

module spi_ram_cmd #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int AUTO_INC  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_SIZE+1:0] rx_data,
   input  logic                 rx_valid,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   output logic                 seq_err
);

   localparam logic [1:0] CMD_WADDR = 2'b00;
   localparam logic [1:0] CMD_WDATA = 2'b01;
   localparam logic [1:0] CMD_RADDR = 2'b10;
   localparam logic [1:0] CMD_RDATA = 2'b11;

   typedef enum logic [1:0] {
      S_NONE = 2'b00,
      S_W    = 2'b01,
      S_R    = 2'b10,
      S_WR   = 2'b11
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_SIZE-1:0] waddr_q, waddr_d;
   logic [ADDR_SIZE-1:0] raddr_q, raddr_d;
   logic [7:0]           tx_data_q;
   logic                 tx_valid_q;
   logic                 seq_err_q, seq_err_d;
   logic                 wr_en, rd_en;

   logic [7:0] mem [MEM_DEPTH];

   logic [1:0]           cmd;
   logic [ADDR_SIZE-1:0] payload;

   assign cmd     = rx_data[ADDR_SIZE+1:ADDR_SIZE];
   assign payload = rx_data[ADDR_SIZE-1:0];

   always_comb begin
      state_d   = state_q;
      waddr_d   = waddr_q;
      raddr_d   = raddr_q;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      seq_err_d = 1'b0;
      // Gating with rst keeps the memory write path from firing on a
      // coincident command while the rest of the block is being reset.
      if (rx_valid && !rst) begin
         case (cmd)
            CMD_WADDR: begin
               waddr_d = payload;
               if (state_q == S_NONE) state_d = S_W;
               else if (state_q == S_R) state_d = S_WR;
            end
            CMD_WDATA: begin
               if (state_q == S_W || state_q == S_WR) begin
                  wr_en = 1'b1;
                  if (AUTO_INC != 0) waddr_d = waddr_q + 1'b1;
               end else begin
                  seq_err_d = 1'b1;
               end
            end
            CMD_RADDR: begin
               raddr_d = payload;
               if (state_q == S_NONE) state_d = S_R;
               else if (state_q == S_W) state_d = S_WR;
            end
            CMD_RDATA: begin
               if (state_q == S_R || state_q == S_WR) begin
                  rd_en = 1'b1;
                  if (AUTO_INC != 0) raddr_d = raddr_q + 1'b1;
               end else begin
                  seq_err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_NONE;
         waddr_q    <= '0;
         raddr_q    <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         seq_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         waddr_q    <= waddr_d;
         raddr_q    <= raddr_d;
         tx_valid_q <= rd_en;
         seq_err_q  <= seq_err_d;
         if (rd_en) tx_data_q <= mem[raddr_q];
      end
   end

   // Memory contents survive reset; only the write enable is reset-gated.
   always_ff @(posedge clk) begin
      if (wr_en) mem[waddr_q] <= rx_data[7:0];
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_ram_cmd.sv
// tb/tb_spi_ram_cmd.sv - directed self-checking bench for spi_ram_cmd
module tb_spi_ram_cmd;

   localparam logic [1:0] WADDR = 2'b00;
   localparam logic [1:0] WDATA = 2'b01;
   localparam logic [1:0] RADDR = 2'b10;
   localparam logic [1:0] RDATA = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] rx_data = '0;
   logic       rx_valid = 1'b0;

   logic [7:0] tx_data_0, tx_data_1;
   logic       tx_valid_0, tx_valid_1;
   logic       seq_err_0, seq_err_1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_ram_cmd #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut0 (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data_0), .tx_valid(tx_valid_0), .seq_err(seq_err_0)
   );

   spi_ram_cmd #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut1 (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data_1), .tx_valid(tx_valid_1), .seq_err(seq_err_1)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // One command on one rising edge; returns 1 time unit after that edge.
   task automatic send(input logic [1:0] c, input logic [7:0] p);
      rx_data  = {c, p};
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = '0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset, then preload address 0 with 0x77 on both instances
      rst = 1'b1;
      idle();
      idle();
      chk("rst_txv0", {7'd0, tx_valid_0}, 8'h00);
      chk("rst_txd0", tx_data_0, 8'h00);
      chk("rst_err0", {7'd0, seq_err_0}, 8'h00);
      rst = 1'b0;
      send(WADDR, 8'h00);
      send(WDATA, 8'h77);

      // 1. Reset with coincident WDATA must not write
      rst = 1'b1;
      send(WDATA, 8'hEE);
      rst = 1'b0;
      chk("t1_txv0", {7'd0, tx_valid_0}, 8'h00);
      chk("t1_err0", {7'd0, seq_err_0}, 8'h00);
      chk("t1_err1", {7'd0, seq_err_1}, 8'h00);
      send(RADDR, 8'h00);
      send(RDATA, 8'h00);
      chk("t1_txv0_rd", {7'd0, tx_valid_0}, 8'h01);
      chk("t1_mem0_a", tx_data_0, 8'h77);
      chk("t1_mem0_b", tx_data_1, 8'h77);

      // 3. Sequence errors from a fresh reset
      rst = 1'b1;
      idle();
      rst = 1'b0;
      send(RDATA, 8'h00);
      chk("t3_rd_err0", {7'd0, seq_err_0}, 8'h01);
      chk("t3_rd_err1", {7'd0, seq_err_1}, 8'h01);
      chk("t3_rd_txv0", {7'd0, tx_valid_0}, 8'h00);
      idle();
      chk("t3_err_drop", {7'd0, seq_err_0}, 8'h00);
      send(WDATA, 8'h11);
      chk("t3_wr_err0", {7'd0, seq_err_0}, 8'h01);
      chk("t3_wr_err1", {7'd0, seq_err_1}, 8'h01);
      send(RADDR, 8'h00);
      chk("t3_raddr_noerr", {7'd0, seq_err_0}, 8'h00);
      send(WDATA, 8'h22);
      chk("t3_wr_in_r_err", {7'd0, seq_err_0}, 8'h01);
      send(RDATA, 8'h00);
      chk("t3_rd_ok_err", {7'd0, seq_err_0}, 8'h00);
      chk("t3_mem0_keep", tx_data_0, 8'h77);

      // 2. Basic write/read with one-cycle tx_valid
      send(WADDR, 8'h3C);
      send(WDATA, 8'hA5);
      send(RADDR, 8'h3C);
      chk("t2_txv_before", {7'd0, tx_valid_0}, 8'h00);
      send(RDATA, 8'h00);
      chk("t2_txv0", {7'd0, tx_valid_0}, 8'h01);
      chk("t2_txd0", tx_data_0, 8'hA5);
      chk("t2_txv1", {7'd0, tx_valid_1}, 8'h01);
      chk("t2_txd1", tx_data_1, 8'hA5);
      idle();
      chk("t2_txv0_drop", {7'd0, tx_valid_0}, 8'h00);
      chk("t2_txd0_hold", tx_data_0, 8'hA5);

      // 5. Back-to-back writes and overwrite
      send(WADDR, 8'h10);
      send(WDATA, 8'h55);
      send(WDATA, 8'h66);
      send(RADDR, 8'h10);
      send(RDATA, 8'h00);
      chk("t5_txd0", tx_data_0, 8'h66);
      chk("t5_txd1", tx_data_1, 8'h55);
      send(RDATA, 8'h00);
      chk("t5_txd1_inc", tx_data_1, 8'h66);
      chk("t5_txd0_same", tx_data_0, 8'h66);
      // WDATA immediately followed by RDATA to the same address
      send(WDATA, 8'h99);
      send(RDATA, 8'h00);
      chk("t5_wr_rd0", tx_data_0, 8'h99);
      chk("t5_wr_rd1", tx_data_1, 8'h99);

      // 4. Auto-increment wrap 0xFF -> 0x00
      send(WADDR, 8'hFF);
      send(WDATA, 8'h01);
      send(WDATA, 8'h02);
      send(RADDR, 8'hFF);
      send(RDATA, 8'h00);
      chk("t4_rd1_d1", tx_data_1, 8'h01);
      chk("t4_rd1_d0", tx_data_0, 8'h02);
      send(RDATA, 8'h00);
      chk("t4_rd2_d1", tx_data_1, 8'h02);
      chk("t4_rd2_v1", {7'd0, tx_valid_1}, 8'h01);
      chk("t4_rd2_d0", tx_data_0, 8'h02);
      send(RADDR, 8'h00);
      send(RDATA, 8'h00);
      chk("t4_addr0_d1", tx_data_1, 8'h02);

      // 6. Reset one cycle after RDATA
      send(RADDR, 8'h3C);
      send(RDATA, 8'h00);
      chk("t6_txv_pre", {7'd0, tx_valid_0}, 8'h01);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      chk("t6_txv0", {7'd0, tx_valid_0}, 8'h00);
      chk("t6_txv1", {7'd0, tx_valid_1}, 8'h00);
      chk("t6_txd0", tx_data_0, 8'h00);
      idle();
      chk("t6_txv0_late", {7'd0, tx_valid_0}, 8'h00);
      send(RDATA, 8'h00);
      chk("t6_state_none0", {7'd0, seq_err_0}, 8'h01);
      chk("t6_state_none1", {7'd0, seq_err_1}, 8'h01);
      chk("t6_no_txv", {7'd0, tx_valid_0}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
